debouncer_bank: RTL and testbench

Multi-channel, parametrised debouncer that filters WIDTH independent noisy inputs, such as buttons, switches or slow status lines. Each channel can use different settle periods for rising and falling transitions. An optional input synchroniser is built in. Each channel also produces single-cycle edge pulses. The block sits between raw pins or slow domains and the user logic, and replaces per-bit single-channel debouncer instances.

---
 rtl/debouncer_bank.sv | 141 ++++++++++++++
 tb/tb_debouncer_bank.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/debouncer_bank.sv
`default_nettype none
// ============================================================================
// Module   : debouncer_bank
// Purpose  : WIDTH independent debounce filters with rise/fall settle periods,
//            optional input synchroniser and single-cycle edge pulses.
// Revision : 1.0
// ============================================================================
module debouncer_bank #(
    parameter int               WIDTH       = 8,
    parameter int               RISE_PERIOD = 256,
    parameter int               FALL_PERIOD = 256,
    parameter int               SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o,
    output logic [WIDTH-1:0] busy_o,
    output logic             any_change_o
);

    localparam int c_max_p = (RISE_PERIOD > FALL_PERIOD) ? RISE_PERIOD : FALL_PERIOD;
    localparam int c_cnt_w = (c_max_p > 1) ? $clog2(c_max_p) : 1;
    localparam logic [c_cnt_w-1:0] c_rise_last = c_cnt_w'(RISE_PERIOD - 1);
    localparam logic [c_cnt_w-1:0] c_fall_last = c_cnt_w'(FALL_PERIOD - 1);

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        CHANGING = 1'b1
    } state_t;

    logic [WIDTH-1:0]   w_s;
    state_t             r_state    [WIDTH];
    state_t             w_state_nxt[WIDTH];
    logic [c_cnt_w-1:0] r_cnt      [WIDTH];
    logic [c_cnt_w-1:0] w_cnt_nxt  [WIDTH];
    logic [WIDTH-1:0]   r_data;
    logic [WIDTH-1:0]   w_data_nxt;
    logic [WIDTH-1:0]   w_rise;
    logic [WIDTH-1:0]   w_fall;
    logic [WIDTH-1:0]   w_busy;
    logic [WIDTH-1:0]   r_rise;
    logic [WIDTH-1:0]   r_fall;
    logic               r_any;

    // The synchroniser runs every cycle so enable never stretches its latency.
    if (SYNC_STAGES > 0) begin : g_sync
        logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;

        always_ff @(posedge clock) begin
            if (reset) begin
                r_sync <= {SYNC_STAGES{RESET_VALUE}};
            end else begin
                r_sync[0] <= data_i;
                for (int k = 1; k < SYNC_STAGES; k++) begin
                    r_sync[k] <= r_sync[k-1];
                end
            end
        end

        assign w_s = r_sync[SYNC_STAGES-1];
    end else begin : g_bypass
        assign w_s = data_i;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_data_nxt  = r_data;
        w_rise      = '0;
        w_fall      = '0;
        w_busy      = '0;
        for (int n = 0; n < WIDTH; n++) begin
            w_busy[n] = (r_state[n] == CHANGING);
            case (r_state[n])
                IDLE: begin
                    w_cnt_nxt[n] = '0;
                    if (w_s[n] != r_data[n]) begin
                        w_state_nxt[n] = CHANGING;
                    end
                end
                CHANGING: begin
                    if (w_s[n] == r_data[n]) begin
                        w_state_nxt[n] = IDLE;
                        w_cnt_nxt[n]   = '0;
                    end else if (r_cnt[n] == (w_s[n] ? c_rise_last : c_fall_last)) begin
                        w_data_nxt[n]  = w_s[n];
                        w_rise[n]      = w_s[n];
                        w_fall[n]      = ~w_s[n];
                        w_state_nxt[n] = IDLE;
                        w_cnt_nxt[n]   = '0;
                    end else begin
                        w_cnt_nxt[n] = r_cnt[n] + c_cnt_w'(1);
                    end
                end
                default: begin
                    w_state_nxt[n] = IDLE;
                    w_cnt_nxt[n]   = '0;
                end
            endcase
        end
    end

    // Pulses clear on every non-enabled clock so they never exceed one cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int n = 0; n < WIDTH; n++) begin
                r_state[n] <= IDLE;
                r_cnt[n]   <= '0;
            end
            r_data <= RESET_VALUE;
            r_rise <= '0;
            r_fall <= '0;
            r_any  <= 1'b0;
        end else begin
            r_rise <= '0;
            r_fall <= '0;
            r_any  <= 1'b0;
            if (enable) begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
                r_data  <= w_data_nxt;
                r_rise  <= w_rise;
                r_fall  <= w_fall;
                r_any   <= |(w_rise | w_fall);
            end
        end
    end

    assign data_o       = r_data;
    assign rise_o       = r_rise;
    assign fall_o       = r_fall;
    assign busy_o       = w_busy;
    assign any_change_o = r_any;

endmodule
`default_nettype wire

// File: tb/tb_debouncer_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_debouncer_bank
// Purpose  : Scoreboard bench for debouncer_bank; expected output values are
//            queued with their due cycle when stimulus is applied.
// Revision : 1.0
// ============================================================================
module tb_debouncer_bank;

    localparam int F_A_DATA = 0;
    localparam int F_A_RISE = 1;
    localparam int F_A_FALL = 2;
    localparam int F_A_BUSY = 3;
    localparam int F_A_ANY  = 4;
    localparam int F_B_DATA = 5;
    localparam int F_B_RISE = 6;
    localparam int F_B_FALL = 7;
    localparam int F_B_BUSY = 8;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       en_a  = 1'b1;
    logic       en_b  = 1'b1;
    logic [3:0] din_a = 4'b0100;
    logic [0:0] din_b = 1'b0;

    logic [3:0] data_a, rise_a, fall_a, busy_a;
    logic       any_a;
    logic [0:0] data_b, rise_b, fall_b, busy_b;
    logic       any_b;

    typedef struct {
        int         cyc;
        int         fld;
        logic [3:0] val;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    debouncer_bank #(
        .WIDTH(4), .RISE_PERIOD(4), .FALL_PERIOD(5), .SYNC_STAGES(0),
        .RESET_VALUE(4'b0100)
    ) u_dut_a (
        .clock(clk), .reset(rst), .enable(en_a), .data_i(din_a),
        .data_o(data_a), .rise_o(rise_a), .fall_o(fall_a), .busy_o(busy_a),
        .any_change_o(any_a)
    );

    debouncer_bank #(
        .WIDTH(1), .RISE_PERIOD(2), .FALL_PERIOD(6), .SYNC_STAGES(2),
        .RESET_VALUE(1'b0)
    ) u_dut_b (
        .clock(clk), .reset(rst), .enable(en_b), .data_i(din_b),
        .data_o(data_b), .rise_o(rise_b), .fall_o(fall_b), .busy_o(busy_b),
        .any_change_o(any_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [3:0] observe(input int fld);
        case (fld)
            F_A_DATA: return data_a;
            F_A_RISE: return rise_a;
            F_A_FALL: return fall_a;
            F_A_BUSY: return busy_a;
            F_A_ANY:  return {3'b000, any_a};
            F_B_DATA: return {3'b000, data_b};
            F_B_RISE: return {3'b000, rise_b};
            F_B_FALL: return {3'b000, fall_b};
            F_B_BUSY: return {3'b000, busy_b};
            default:  return 4'hx;
        endcase
    endfunction

    task automatic expect_at(input int at, input int fld, input logic [3:0] val, input string tag);
        exp_t item;
        item.cyc = at;
        item.fld = fld;
        item.val = val;
        item.tag = tag;
        sb.push_back(item);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Outputs are sampled on the falling edge, after edge number cyc.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                check_val(sb[i].tag, 32'(observe(sb[i].fld)), 32'(sb[i].val));
                sb.delete(i);
            end
        end
    end

    initial begin
        int c;
        int e;

        expect_at(2, F_A_DATA, 4'b0100, "rst_data_a");
        expect_at(2, F_A_RISE, 4'b0000, "rst_rise_a");
        expect_at(2, F_A_FALL, 4'b0000, "rst_fall_a");
        expect_at(2, F_A_BUSY, 4'b0000, "rst_busy_a");
        expect_at(2, F_A_ANY,  4'b0000, "rst_any_a");
        expect_at(2, F_B_DATA, 4'b0000, "rst_data_b");
        expect_at(2, F_B_BUSY, 4'b0000, "rst_busy_b");
        tick(3);
        rst = 1'b0;
        tick(2);

        // Channel 2 starts falling from its reset value 1; reset aborts it.
        c = cyc; e = c + 1;
        din_a = 4'b0000;
        expect_at(e,     F_A_BUSY, 4'b0100, "rm_busy_e1");
        expect_at(e + 2, F_A_BUSY, 4'b0100, "rm_busy_3rd");
        expect_at(e + 3, F_A_DATA, 4'b0100, "rm_data_rst");
        expect_at(e + 3, F_A_BUSY, 4'b0000, "rm_busy_rst");
        expect_at(e + 3, F_A_FALL, 4'b0000, "rm_fall_rst");
        expect_at(e + 4, F_A_BUSY, 4'b0100, "rm_busy_restart");
        expect_at(e + 5, F_A_FALL, 4'b0000, "rm_no_early_fall");
        expect_at(e + 8, F_A_DATA, 4'b0100, "rm_data_hold");
        expect_at(e + 9, F_A_DATA, 4'b0000, "rm_data_fell");
        expect_at(e + 9, F_A_FALL, 4'b0100, "rm_fall_pulse");
        expect_at(e + 10, F_A_FALL, 4'b0000, "rm_fall_end");
        tick(3);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(8);

        // Three-cycle glitch on channel 0 (rise period 4).
        c = cyc; e = c + 1;
        din_a = 4'b0001;
        expect_at(e,     F_A_BUSY, 4'b0001, "gl_busy_1");
        expect_at(e + 2, F_A_BUSY, 4'b0001, "gl_busy_3");
        expect_at(e + 3, F_A_BUSY, 4'b0000, "gl_busy_end");
        expect_at(e + 4, F_A_DATA, 4'b0000, "gl_data");
        expect_at(e + 4, F_A_RISE, 4'b0000, "gl_no_rise");
        tick(3);
        din_a = 4'b0000;
        tick(5);

        // Channels 0 and 3 rise together; channel 1 glitches for two cycles.
        c = cyc; e = c + 1;
        din_a = 4'b1011;
        expect_at(e,     F_A_BUSY, 4'b1011, "mc_busy_e1");
        expect_at(e + 2, F_A_BUSY, 4'b1001, "mc_busy_rej");
        expect_at(e + 3, F_A_DATA, 4'b0000, "mc_data_pre");
        expect_at(e + 3, F_A_RISE, 4'b0000, "mc_rise_pre");
        expect_at(e + 4, F_A_DATA, 4'b1001, "mc_data");
        expect_at(e + 4, F_A_RISE, 4'b1001, "mc_rise");
        expect_at(e + 4, F_A_ANY,  4'b0001, "mc_any");
        expect_at(e + 4, F_A_BUSY, 4'b0000, "mc_busy_done");
        expect_at(e + 5, F_A_RISE, 4'b0000, "mc_rise_end");
        expect_at(e + 5, F_A_ANY,  4'b0000, "mc_any_end");
        tick(2);
        din_a = 4'b1001;
        tick(6);

        // Channel 1 rises with enable high on alternate cycles only.
        c = cyc;
        din_a = 4'b1011;
        expect_at(c + 1,  F_A_BUSY, 4'b0010, "en_busy_start");
        expect_at(c + 8,  F_A_BUSY, 4'b0010, "en_busy_held");
        expect_at(c + 8,  F_A_DATA, 4'b1001, "en_data_pre");
        expect_at(c + 8,  F_A_RISE, 4'b0000, "en_rise_pre");
        expect_at(c + 9,  F_A_DATA, 4'b1011, "en_data");
        expect_at(c + 9,  F_A_RISE, 4'b0010, "en_rise");
        expect_at(c + 9,  F_A_ANY,  4'b0001, "en_any");
        expect_at(c + 10, F_A_RISE, 4'b0000, "en_rise_end");
        expect_at(c + 10, F_A_ANY,  4'b0000, "en_any_end");
        for (int k = 0; k < 12; k++) begin
            en_a = (k % 2 == 0);
            tick(1);
        end
        en_a = 1'b1;

        // Channel 0 falls (fall period 5).
        c = cyc; e = c + 1;
        din_a = 4'b1010;
        expect_at(e + 4, F_A_DATA, 4'b1011, "fa_data_pre");
        expect_at(e + 4, F_A_FALL, 4'b0000, "fa_fall_pre");
        expect_at(e + 5, F_A_DATA, 4'b1010, "fa_data");
        expect_at(e + 5, F_A_FALL, 4'b0001, "fa_fall");
        expect_at(e + 5, F_A_RISE, 4'b0000, "fa_no_rise");
        expect_at(e + 5, F_A_ANY,  4'b0001, "fa_any");
        expect_at(e + 6, F_A_FALL, 4'b0000, "fa_fall_end");
        tick(8);

        // Two-stage synchroniser ahead of asymmetric periods (2 up, 6 down).
        c = cyc;
        din_b = 1'b1;
        expect_at(c + 2, F_B_BUSY, 4'b0000, "as_busy_sync");
        expect_at(c + 3, F_B_BUSY, 4'b0001, "as_busy_e1");
        expect_at(c + 4, F_B_DATA, 4'b0000, "as_data_pre");
        expect_at(c + 5, F_B_DATA, 4'b0001, "as_data_rise");
        expect_at(c + 5, F_B_RISE, 4'b0001, "as_rise");
        expect_at(c + 6, F_B_RISE, 4'b0000, "as_rise_end");
        tick(8);
        c = cyc;
        din_b = 1'b0;
        expect_at(c + 8,  F_B_DATA, 4'b0001, "as_data_hold");
        expect_at(c + 8,  F_B_FALL, 4'b0000, "as_fall_pre");
        expect_at(c + 9,  F_B_DATA, 4'b0000, "as_data_fall");
        expect_at(c + 9,  F_B_FALL, 4'b0001, "as_fall");
        expect_at(c + 10, F_B_FALL, 4'b0000, "as_fall_end");
        tick(12);

        check_val("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
